decode_queue_stage: RTL and testbench
=====================================

DECODE_QUEUE_STAGE -- requirements
Module: decode_queue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries; power of 2, at least 2.
REQ-003 SHALL have parameter NUM_BYP, default 3, downstream bypass sources; index 0 is youngest (X).
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  synchronous queue/stage kill (redirect).
REQ-007 SHALL have ports if_vld in 1, if_instr in XLEN, if_pc in XLEN, if_rdy out 1; fetch valid/ready.
REQ-008 SHALL have ports rf_rs1 out 5, rf_rs2 out 5, rf_rs1_data in XLEN, rf_rs2_data in XLEN; asynchronous-read register file.
REQ-009 SHALL have ports byp_vld in NUM_BYP, byp_rd in NUM_BYP*5, byp_data in NUM_BYP*XLEN, byp_data_rdy in NUM_BYP (0 = result not yet available, e.g. a load in flight).
REQ-010 SHALL have ports d_vld out 1 and x_rdy in 1; valid/ready handshake to X.
REQ-011 SHALL have outputs d_pkt out dec_pkt_t, d_op1 out XLEN, d_op2 out XLEN, d_store_data out XLEN, d_br_tgt out XLEN, d_illegal out 1.
REQ-012 SHALL have output iq_count out $clog2(IQ_DEPTH)+1, current occupancy.

Function
REQ-013 SHALL enqueue {if_instr, if_pc} on clk when if_vld && if_rdy && !flush.
REQ-014 SHALL drive if_rdy = (iq_count < IQ_DEPTH), registered-state only, with no combinational path from x_rdy; a full queue SHALL NOT accept an entry even when dequeuing in the same cycle.
REQ-015 SHALL make an enqueued entry visible at the head no earlier than the next cycle (1-cycle fetch-to-decode latency).
REQ-016 SHALL dequeue the head when d_vld && x_rdy; simultaneous enqueue and dequeue SHALL leave iq_count unchanged.
REQ-017 SHALL wrap read and write pointers modulo IQ_DEPTH.
REQ-018 SHALL, on flush, set iq_count and both pointers to 0, drop any same-cycle enqueue, and force d_vld=0 that cycle.
REQ-019 SHALL decode the head combinationally: rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12]; formats U/J/I/B/S/R map to RV32I opcodes.
REQ-020 SHALL generate sign-extended immediates per RV32I I/S/B/U/J rules, with imm=0 for R-type and illegal.
REQ-021 SHALL set d_illegal=1 for any opcode outside RV32I base (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM); illegal entries SHALL have rf_wen=0 and dmem_vld=0.
REQ-022 SHALL resolve each valid, nonzero source by priority over byp index 0..NUM_BYP-1 (first match of byp_vld && byp_rd==rs wins), else use RF data; rs==x0 SHALL yield 0.
REQ-023 SHALL flag a hazard if the winning bypass match has byp_data_rdy=0.
REQ-024 SHALL drive d_vld = (iq_count!=0) && !hazard && !flush; the head SHALL be held while hazard persists.
REQ-025 SHALL drive d_op1 = resolved rs1, or pc for AUIPC, or 0 for LUI.
REQ-026 SHALL drive d_op2 = resolved rs2 for OP, else imm; d_store_data = resolved rs2; d_br_tgt = pc+imm mod 2^XLEN.
REQ-027 SHALL have dec_pkt_t carry rd, rf_wen, alu_op (funct3, aux = instr[30] except ADDI forces 0), dmem_vld, dmem_wr, dmem_len (1/2/4 bytes from funct3[1:0]), dmem_unsigned, is_branch, is_jal, is_jalr.
REQ-028 SHALL keep outputs stable while d_vld && !x_rdy.

Reset
REQ-029 SHALL, on rst, clear iq_count, pointers, and entry valid state immediately (asynchronously) with if_rdy=1 and d_vld=0; entry payload need not reset.
REQ-030 SHALL, when rst is asserted mid-transfer, lose all queued entries with no handshake completing that cycle.

Structure
REQ-031 SHALL place dec_pkt_t, the format enumeration and the opcode constants in core_types_pkg/riscv_pkg.
REQ-032 SHALL implement the queue as sub-module decode_iq (parametrised by width and depth, with count/full/empty); decode, bypass and hazard logic SHALL sit in the top.

Verification
REQ-033 SHALL test 5 back-to-back enqueues with x_rdy=0, IQ_DEPTH=4 -> if_rdy drops after the 4th, iq_count=4, and the 5th is held by fetch.
REQ-034 SHALL test ADDI x1,x0,5 followed by ADD x2,x1,x1 with byp0 {rd=1, data=5, rdy=1} -> d_op1=d_op2=5.
REQ-035 SHALL test head ADD x3,x1,x2 with byp0 {rd=1, rdy=0} -> d_vld=0 until rdy=1, then one transfer.
REQ-036 SHALL test matches on x5 at byp1 (data 7) and byp2 (data 9) -> d_op1=7.
REQ-037 SHALL test flush with 3 entries queued and a simultaneous if_vld -> iq_count=0 next cycle and no d_vld.
REQ-038 SHALL test opcode 7'h7F -> d_illegal=1, rf_wen=0, dmem_vld=0, and a normal dequeue.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcode constants, instruction formats and the
// decoded packet handed from the decode stage to execute.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

  typedef struct packed {
    logic       aux;
    logic [2:0] funct3;
  } alu_op_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rf_wen;
    alu_op_t    alu_op;
    logic       dmem_vld;
    logic       dmem_wr;
    logic [2:0] dmem_len;
    logic       dmem_unsigned;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
  } dec_pkt_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC:                              return FMT_U;
      OPC_JAL:                                         return FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: return FMT_I;
      OPC_BRANCH:                                      return FMT_B;
      OPC_STORE:                                       return FMT_S;
      OPC_OP:                                          return FMT_R;
      default:                                         return FMT_ILL;
    endcase
  endfunction

  // Access size in bytes from funct3[1:0]; the reserved encoding maps to a word.
  function automatic logic [2:0] mem_len(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/decode_iq.sv
// Circular instruction queue between fetch and decode; storage is not reset,
// only pointers and occupancy are.
module decode_iq #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr        = push && !full && !flush;
  assign rd        = pop && !empty && !flush;
  assign head_data = mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: fetch queue, RV32I decode, operand bypass and load-use hazard
// stall. Handshakes are valid/ready: a beat moves on a rising edge when both are 1.
module decode_queue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IQ_DEPTH = 4,
  parameter int NUM_BYP  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        if_vld,
  input  logic [XLEN-1:0]             if_instr,
  input  logic [XLEN-1:0]             if_pc,
  output logic                        if_rdy,
  output logic [4:0]                  rf_rs1,
  output logic [4:0]                  rf_rs2,
  input  logic [XLEN-1:0]             rf_rs1_data,
  input  logic [XLEN-1:0]             rf_rs2_data,
  input  logic [NUM_BYP-1:0]          byp_vld,
  input  logic [NUM_BYP*5-1:0]        byp_rd,
  input  logic [NUM_BYP*XLEN-1:0]     byp_data,
  input  logic [NUM_BYP-1:0]          byp_data_rdy,
  output logic                        d_vld,
  input  logic                        x_rdy,
  output dec_pkt_t                    d_pkt,
  output logic [XLEN-1:0]             d_op1,
  output logic [XLEN-1:0]             d_op2,
  output logic [XLEN-1:0]             d_store_data,
  output logic [XLEN-1:0]             d_br_tgt,
  output logic                        d_illegal,
  output logic [$clog2(IQ_DEPTH):0]   iq_count
);
  logic [2*XLEN-1:0] head_data;
  logic [XLEN-1:0]   head_instr, head_pc;
  logic              iq_full, iq_empty, enq, deq, hazard;

  // if_rdy depends only on registered occupancy, so a full queue refuses
  // fetch even in a cycle where X drains the head.
  assign if_rdy = !iq_full;
  assign enq    = if_vld && !iq_full && !flush;
  assign deq    = d_vld && x_rdy;

  decode_iq #(.W(2*XLEN), .DEPTH(IQ_DEPTH)) u_iq (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (enq),
    .push_data ({if_instr, if_pc}),
    .pop       (deq),
    .head_data (head_data),
    .count     (iq_count),
    .full      (iq_full),
    .empty     (iq_empty)
  );

  assign head_instr = head_data[2*XLEN-1:XLEN];
  assign head_pc    = head_data[XLEN-1:0];

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  fmt_e        fmt;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic        illegal, use_rs1, use_rs2;

  assign ins     = head_instr[31:0];
  assign opcode  = ins[6:0];
  assign rd      = ins[11:7];
  assign funct3  = ins[14:12];
  assign rs1     = ins[19:15];
  assign rs2     = ins[24:20];
  assign fmt     = opcode_fmt(opcode);
  assign illegal = (fmt == FMT_ILL);
  assign use_rs1 = opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
  assign use_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign rf_rs1  = rs1;
  assign rf_rs2  = rs2;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  // Lowest bypass index is youngest and therefore wins on multiple matches.
  logic            hit1, hit2, rdy1, rdy2;
  logic [XLEN-1:0] byp1, byp2, rs1_val, rs2_val;
  always_comb begin
    hit1 = 1'b0; rdy1 = 1'b0; byp1 = '0;
    hit2 = 1'b0; rdy2 = 1'b0; byp2 = '0;
    for (int i = 0; i < NUM_BYP; i++) begin
      if (!hit1 && byp_vld[i] && byp_rd[i*5 +: 5] == rs1) begin
        hit1 = 1'b1;
        rdy1 = byp_data_rdy[i];
        byp1 = byp_data[i*XLEN +: XLEN];
      end
      if (!hit2 && byp_vld[i] && byp_rd[i*5 +: 5] == rs2) begin
        hit2 = 1'b1;
        rdy2 = byp_data_rdy[i];
        byp2 = byp_data[i*XLEN +: XLEN];
      end
    end
  end

  assign rs1_val = (rs1 == 5'd0) ? '0 : (hit1 ? byp1 : rf_rs1_data);
  assign rs2_val = (rs2 == 5'd0) ? '0 : (hit2 ? byp2 : rf_rs2_data);
  assign hazard  = (use_rs1 && rs1 != 5'd0 && hit1 && !rdy1) ||
                   (use_rs2 && rs2 != 5'd0 && hit2 && !rdy2);
  assign d_vld   = !iq_empty && !hazard && !flush;

  always_comb begin
    d_op1 = rs1_val;
    if (opcode == OPC_AUIPC) d_op1 = head_pc;
    else if (opcode == OPC_LUI) d_op1 = '0;
  end

  assign d_op2        = (opcode == OPC_OP) ? rs2_val : imm;
  assign d_store_data = rs2_val;
  assign d_br_tgt     = head_pc + imm;
  assign d_illegal    = illegal;

  always_comb begin
    d_pkt               = '0;
    d_pkt.rd            = rd;
    d_pkt.rf_wen        = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                                         OPC_LOAD, OPC_OPIMM, OPC_OP};
    d_pkt.alu_op.funct3 = funct3;
    // ADDI has no subtract form, so bit 30 is immediate data there.
    d_pkt.alu_op.aux    = ins[30] && !(opcode == OPC_OPIMM && funct3 == 3'b000);
    d_pkt.dmem_vld      = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    d_pkt.dmem_wr       = (opcode == OPC_STORE);
    d_pkt.dmem_len      = mem_len(funct3[1:0]);
    d_pkt.dmem_unsigned = (opcode == OPC_LOAD) && funct3[2];
    d_pkt.is_branch     = (opcode == OPC_BRANCH);
    d_pkt.is_jal        = (opcode == OPC_JAL);
    d_pkt.is_jalr       = (opcode == OPC_JALR);
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: decode vector table through a scoreboard, plus
// hand sequences for backpressure, bypass priority, hazard, flush and reset.
module tb_decode_queue_stage;
  import riscv_pkg::*;

  localparam int EW = 105;

  logic        clk = 1'b0;
  logic        rst, flush, if_vld, if_rdy, d_vld, x_rdy, d_illegal;
  logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [2:0]  byp_vld, byp_data_rdy, iq_count;
  logic [14:0] byp_rd;
  logic [95:0] byp_data;
  dec_pkt_t    d_pkt;
  logic [31:0] d_op1, d_op2, d_store_data, d_br_tgt;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [EW-1:0] exp;
  } vec_t;
  vec_t vt[11];

  decode_queue_stage #(.XLEN(32), .IQ_DEPTH(4), .NUM_BYP(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_vld(if_vld), .if_instr(if_instr), .if_pc(if_pc), .if_rdy(if_rdy),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .byp_vld(byp_vld), .byp_rd(byp_rd), .byp_data(byp_data), .byp_data_rdy(byp_data_rdy),
    .d_vld(d_vld), .x_rdy(x_rdy), .d_pkt(d_pkt), .d_op1(d_op1), .d_op2(d_op2),
    .d_store_data(d_store_data), .d_br_tgt(d_br_tgt), .d_illegal(d_illegal),
    .iq_count(iq_count)
  );

  // clock / register-file model
  always #5 clk = ~clk;
  assign rf_rs1_data = 32'hA000_0000 | {27'd0, rf_rs1};
  assign rf_rs2_data = 32'hA000_0000 | {27'd0, rf_rs2};

  function automatic logic [EW-1:0] mk(input logic [31:0] op1, op2, tgt,
                                       input logic ill, wen, dmem, aux,
                                       input logic [4:0] rd);
    return {op1, op2, tgt, ill, wen, dmem, aux, rd};
  endfunction

  function automatic logic [31:0] addi_x1(input int k);
    logic [11:0] imm12 = 12'(k);
    return {imm12, 5'd0, 3'd0, 5'd1, 7'b0010011};
  endfunction

  function automatic logic [EW-1:0] addi_exp(input int k, input logic [31:0] pc);
    return mk(32'd0, 32'(k), pc + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every completed handshake is compared with the oldest expectation
  always @(negedge clk) begin
    logic [EW-1:0] act;
    if (!rst && d_vld && x_rdy) begin
      n_xfer++;
      act = {d_op1, d_op2, d_br_tgt, d_illegal, d_pkt.rf_wen, d_pkt.dmem_vld,
             d_pkt.alu_op.aux, d_pkt.rd};
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", act, '0);
      end else begin
        check("xfer", act, exp_q.pop_front());
      end
    end
  end

  // driver tasks: called and returning at posedge+1
  task automatic enq(input logic [31:0] instr, pc, input logic [EW-1:0] e);
    bit ok;
    ok       = 1'b0;
    if_vld   = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if_rdy) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if_vld = 1'b0;
    if (!ok) check("enq_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && iq_count == 3'd0) done = 1'b1;
    end
    check(name, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic byp_clear();
    byp_vld = '0; byp_rd = '0; byp_data = '0; byp_data_rdy = '0;
  endtask

  initial begin
    int x0;
    rst = 1'b1; flush = 1'b0; if_vld = 1'b0; if_instr = '0; if_pc = '0; x_rdy = 1'b0;
    byp_clear();

    vt[0]  = '{32'h00500093, 32'h100, mk(32'h0,        32'h5,        32'h105,      0, 1, 0, 0, 5'd1)};
    vt[1]  = '{32'h00108133, 32'h104, mk(32'hA0000001, 32'hA0000001, 32'h104,      0, 1, 0, 0, 5'd2)};
    vt[2]  = '{32'h123452B7, 32'h108, mk(32'h0,        32'h12345000, 32'h12345108, 0, 1, 0, 0, 5'd5)};
    vt[3]  = '{32'hFFFFF317, 32'h10C, mk(32'h10C,      32'hFFFFF000, 32'hFFFFF10C, 0, 1, 0, 1, 5'd6)};
    vt[4]  = '{32'hFE742E23, 32'h110, mk(32'hA0000008, 32'hFFFFFFFC, 32'h10C,      0, 0, 1, 1, 5'd28)};
    vt[5]  = '{32'hFE208CE3, 32'h114, mk(32'hA0000001, 32'hFFFFFFF8, 32'h10C,      0, 0, 0, 1, 5'd25)};
    vt[6]  = '{32'h001000EF, 32'h118, mk(32'h0,        32'h800,      32'h918,      0, 1, 0, 0, 5'd1)};
    vt[7]  = '{32'h01012183, 32'h11C, mk(32'hA0000002, 32'h10,       32'h12C,      0, 1, 1, 0, 5'd3)};
    vt[8]  = '{32'hFFF0807F, 32'h120, mk(32'hA0000001, 32'h0,        32'h120,      1, 0, 0, 1, 5'd0)};
    vt[9]  = '{32'hC0000093, 32'h124, mk(32'h0,        32'hFFFFFC00, 32'hFFFFFD24, 0, 1, 0, 0, 5'd1)};
    vt[10] = '{32'h40325213, 32'h128, mk(32'hA0000004, 32'h403,      32'h52B,      0, 1, 0, 1, 5'd4)};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_if_rdy", if_rdy, 1);
    check("rst_d_vld", d_vld, 0);
    check("rst_iq_count", iq_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // decode table, streaming with X always ready
    x_rdy = 1'b1;
    for (int i = 0; i < 11; i++) enq(vt[i].instr, vt[i].pc, vt[i].exp);
    drain("table_drain");

    // five back-to-back enqueues into a stalled X
    x_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if_vld = 1'b1; if_instr = addi_x1(k); if_pc = 32'h200 + 32'(4*k);
      @(negedge clk);
      check("bb_if_rdy", if_rdy, (k <= 4));
      if (k == 1) check("first_latency_d_vld", d_vld, 0);
      if (k == 2) check("head_next_cycle_d_vld", d_vld, 1);
      if (if_rdy) exp_q.push_back(addi_exp(k, if_pc));
      if (k < 5) begin @(posedge clk); #1; end
    end
    check("bb_count_full", iq_count, 4);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_if_rdy", if_rdy, 0);
    check("held_count", iq_count, 4);
    check("stall_d_vld", d_vld, 1);
    check("stall_op2_stable", d_op2, 1);
    @(posedge clk); #1;
    x_rdy = 1'b1;
    @(negedge clk);
    check("full_deq_no_accept", if_rdy, 0);
    @(posedge clk); #1;
    enq(addi_x1(5), 32'h214, addi_exp(5, 32'h214));
    drain("bb_drain");

    // bypass from byp0 into both ADD sources
    byp_vld = 3'b001; byp_rd = 15'd1; byp_data = 96'd5; byp_data_rdy = 3'b001;
    enq(vt[0].instr, vt[0].pc, vt[0].exp);
    enq(32'h00108133, 32'h104, mk(32'd5, 32'd5, 32'h104, 0, 1, 0, 0, 5'd2));
    drain("byp0_drain");

    // x0 source ignores a matching, not-ready bypass
    byp_vld = 3'b001; byp_rd = 15'd0; byp_data = 96'hDEAD; byp_data_rdy = 3'b000;
    enq(vt[0].instr, vt[0].pc, vt[0].exp);
    drain("x0_no_hazard_drain");

    // load-use hazard holds the head until data is ready
    byp_vld = 3'b001; byp_rd = 15'd1; byp_data = 96'h33; byp_data_rdy = 3'b000;
    x0 = n_xfer;
    enq(32'h002081B3, 32'h300, mk(32'h33, 32'hA0000002, 32'h300, 0, 1, 0, 0, 5'd3));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hazard_d_vld", d_vld, 0);
      check("hazard_count", iq_count, 1);
      @(posedge clk); #1;
    end
    byp_data_rdy = 3'b001;
    drain("hazard_drain");
    check("hazard_one_xfer", n_xfer - x0, 1);

    // priority: byp1 beats byp2, byp0 does not match
    byp_vld = 3'b111; byp_rd = {5'd5, 5'd5, 5'd3};
    byp_data = {32'd9, 32'd7, 32'h44}; byp_data_rdy = 3'b011;
    enq(32'h00028333, 32'h400, mk(32'd7, 32'd0, 32'h400, 0, 1, 0, 0, 5'd6));
    drain("byp_prio_drain");
    byp_clear();

    // flush with three entries and a same-cycle fetch
    x_rdy = 1'b0;
    for (int k = 1; k <= 3; k++) enq(addi_x1(k), 32'h500 + 32'(4*k), addi_exp(k, 32'h500 + 32'(4*k)));
    @(negedge clk);
    check("pre_flush_count", iq_count, 3);
    @(posedge clk); #1;
    flush = 1'b1; if_vld = 1'b1; if_instr = addi_x1(9); if_pc = 32'h600;
    @(negedge clk);
    check("flush_d_vld", d_vld, 0);
    @(posedge clk); #1;
    flush = 1'b0; if_vld = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_flush_count", iq_count, 0);
    check("post_flush_d_vld", d_vld, 0);
    @(posedge clk); #1;

    // reset asserted while a transfer is about to happen
    enq(addi_x1(1), 32'h700, addi_exp(1, 32'h700));
    enq(addi_x1(2), 32'h704, addi_exp(2, 32'h704));
    x_rdy = 1'b1; rst = 1'b1;
    #1;
    check("async_rst_d_vld", d_vld, 0);
    check("async_rst_count", iq_count, 0);
    check("async_rst_if_rdy", if_rdy, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", iq_count, 0);
    check("post_rst_d_vld", d_vld, 0);
    @(posedge clk); #1;

    // final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
